// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW           = 9;
    localparam int unsigned DEF_DW           = 16;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned STARVE_W         = 3;

    // RAM margin / retention tie-offs
    localparam logic [2:0] EMA_TIE   = 3'b000;
    localparam logic [1:0] EMAW_TIE  = 2'b00;
    localparam logic       EMAS_TIE  = 1'b0;
    localparam logic       RET1N_TIE = 1'b1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive data grants while fetch waits; withholds data grants at the limit.
module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_if_valid,
    input  logic i_if_grant,
    input  logic i_dm_grant,
    output logic o_dm_allow_c
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve_cnt;

    // Saturating count of data grants made while a fetch is pending
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= '0;
        end else if (!i_if_valid || i_if_grant) begin
            r_starve_cnt <= '0;
        end else if (i_dm_grant && (r_starve_cnt < LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    assign o_dm_allow_c = (r_starve_cnt < LIMIT) || !i_if_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM front end: boot load sequencing, fetch/data arbitration, registered responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    input  logic          dm_req_valid,
    output logic          dm_req_ready,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_rsp_valid,
    output logic [DW-1:0] dm_rsp_data,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q,
    output logic [2:0]    ram_ema,
    output logic [1:0]    ram_emaw,
    output logic          ram_emas,
    output logic          ram_ret1n,
    output logic          boot_done
);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_dm_allow;
    logic   w_dm_gnt;
    logic   w_if_gnt;

    mem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .CLK          (CLK),
        .RST          (RST),
        .i_if_valid   (if_req_valid),
        .i_if_grant   (w_if_gnt),
        .i_dm_grant   (w_dm_gnt),
        .o_dm_allow_c (w_dm_allow)
    );

    // State register; reset always returns to the program-load state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant selection and RAM port drive
    always_comb begin
        w_state_nxt = r_state;
        w_dm_gnt    = 1'b0;
        w_if_gnt    = 1'b0;
        ram_cen     = 1'b0;
        ram_wen     = 1'b0;
        ram_a       = '0;
        ram_d       = '0;
        boot_done   = 1'b0;
        case (r_state)
            S_LOAD: begin
                ram_cen     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                boot_done = 1'b1;
                if (dm_req_valid && w_dm_allow) begin
                    w_dm_gnt = 1'b1;
                    ram_a    = dm_addr;
                    ram_wen  = dm_we;
                    ram_d    = dm_wdata;
                end else if (if_req_valid) begin
                    w_if_gnt = 1'b1;
                    ram_a    = if_addr;
                    ram_d    = dm_wdata;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    assign if_req_ready = w_if_gnt;
    assign dm_req_ready = w_dm_gnt;

    // One-cycle response pulses; data held between transfers
    always_ff @(posedge CLK) begin
        if (RST) begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= w_if_gnt;
            dm_rsp_valid <= w_dm_gnt;
            if (w_if_gnt) begin
                if_rsp_data <= ram_q;
            end
            if (w_dm_gnt) begin
                dm_rsp_data <= dm_we ? dm_wdata : ram_q;
            end
        end
    end

    assign ram_ema   = EMA_TIE;
    assign ram_emaw  = EMAW_TIE;
    assign ram_emas  = EMAS_TIE;
    assign ram_ret1n = RET1N_TIE;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port front end for the 16-bit × 512-word program/data RAM. It owns the RAM's only port and arbitrates between the instruction-fetch requester and the data (load/store) requester using valid/ready handshakes, with registered 1-cycle read responses. It sequences the post-reset program load, pulsing the RAM's load strobe, and drives the RAM's margin/retention tie-offs.

## Interface
Parameters:
- AW, 9, address width (512 words)
- DW, 16, data width
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is waiting

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  AW  fetch word address
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse
- if_rsp_data  out  DW  fetch data
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data request accepted this cycle
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_rsp_valid  out  1  load data or store acknowledge, one-cycle pulse
- dm_rsp_data  out  DW  load data (on a store: echo of dm_wdata)
- ram_cen  out  1  1 = RAM loads its program image at the clock edge
- ram_wen  out  1  1 = RAM writes ram_d at ram_a at the clock edge
- ram_a  out  AW  RAM address
- ram_d  out  DW  RAM write data
- ram_q  in  DW  RAM read data (combinational from ram_a)
- ram_ema  out  3  constant 3'b000
- ram_emaw  out  2  constant 2'b00
- ram_emas  out  1  constant 0
- ram_ret1n  out  1  constant 1
- boot_done  out  1  1 in S_RUN

## Operation
- FSM has two states, S_LOAD and S_RUN. RST forces S_LOAD. S_LOAD always goes to S_RUN on the next cycle when RST is low. S_RUN stays in S_RUN until RST.
- ram_cen = (state == S_LOAD). It is therefore high throughout reset and for the first cycle after RST falls. Reloading is idempotent.
- In S_LOAD: both readys are 0, ram_wen = 0, boot_done = 0.
- Arbitration in S_RUN (combinational):
  - Grant data if dm_req_valid and (starve_cnt < STARVE_LIMIT or !if_req_valid).
  - Otherwise grant fetch if if_req_valid.
  - At most one ready is high per cycle.
- Transfer on a requester = valid & ready. Requesters must hold valid and payload until the transfer; valid must not depend on ready.
- starve_cnt (3 bits, saturating at STARVE_LIMIT):
  - Increments on each data grant while if_req_valid = 1.
  - Clears on a fetch grant or whenever if_req_valid = 0.
- RAM drive on the granted cycle:
  - ram_a = granted address.
  - ram_wen = dm_we for a data grant, 0 for a fetch grant.
  - ram_d = dm_wdata.
- When nothing is granted: ram_a = 0, ram_d = 0, ram_wen = 0.
- Responses:
  - On a transfer, the response register captures ram_q (load/fetch) or dm_wdata (store).
  - The matching rsp_valid is high for exactly the next cycle.
- Reset values: if_rsp_valid = 0, dm_rsp_valid = 0, if_rsp_data = 0, dm_rsp_data = 0, starve_cnt = 0, state = S_LOAD.
- Reset mid-operation: any pending response is dropped (no rsp_valid). Stores already committed are overwritten by the program reload.

## Timing
- Read latency: request transferred in cycle N, rsp_valid and data present in cycle N+1.
- Throughput: one transfer per cycle, back-to-back, either requester.
- A store at cycle N followed by a load of the same address at N+1 returns the new data.
- Same-cycle requests on both ports: only one proceeds; the loser waits with ready = 0.
- ready is a combinational function of both valids, dm_we-independent, plus registered state.
- First request can be accepted in the 2nd cycle after RST deasserts.

## Structure
- Package mem_arb_pkg holds:
  - The state enum (S_LOAD, S_RUN).
  - AW/DW defaults and STARVE_LIMIT.
  - The tie-off constants: EMA 3'b000, EMAW 2'b00, EMAS 0, RET1N 1.
- One sub-module, mem_arb_starve_guard: starve_cnt plus the data-grant qualifier. The top level holds the FSM, muxing and response registers.

## Test plan
- Reset release → ram_cen = 1 in the first post-reset cycle, 0 thereafter; boot_done rises in cycle 2; no rsp_valid pulses.
- Fetch addr 0x010 with RAM word 0xA5A5 → if_req_ready the same cycle; if_rsp_valid with 0xA5A5 next cycle.
- Store 0x1234 to 0x1FF, then load 0x1FF on the following cycle → ram_wen pulses once; dm_rsp_data = 0x1234 on both responses.
- Both valid continuously → 4 data grants, 1 fetch grant, repeating; no fetch wait exceeds 4 cycles.
- Data valid only, streaming 8 loads → 8 consecutive grants and 8 consecutive dm_rsp_valid cycles; if_req_ready stays 0.
- RST asserted the cycle after a load is accepted → no dm_rsp_valid; ram_cen high; previously stored word reverts to the image value after boot.
